mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port memory controller with fixed read latency.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; fixed priority (requester 0) otherwise.
module mem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_0,
  input  logic                  req_1,
  input  logic                  rd_wr_0,
  input  logic                  rd_wr_1,
  input  logic [ADDR_WIDTH-1:0] addr_0,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [DATA_WIDTH-1:0] wr_data_0,
  input  logic [DATA_WIDTH-1:0] wr_data_1,
  output logic                  gnt_0,
  output logic                  gnt_1,
  output logic                  rd_valid_0,
  output logic                  rd_valid_1,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  mem_rd_wr_valid,
  output logic                  mem_rd_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RD_WAIT
  } state_t;

  // Counter is loaded with latency-1 so that RD_WAIT lasts exactly RD_LATENCY cycles.
  localparam logic [3:0] CNT_LOAD = 4'(RD_LATENCY - 1);

  state_t                  state_reg;
  logic [3:0]              cnt_reg;
  logic [1:0]              gnt_reg;
  logic [1:0]              rd_valid_reg;
  logic                    mem_valid_reg;
  logic                    mem_rd_wr_reg;
  logic [ADDR_WIDTH-1:0]   mem_addr_reg;
  logic [DATA_WIDTH-1:0]   mem_wr_data_reg;
  logic [DATA_WIDTH-1:0]   rd_data_reg;
  logic                    owner_reg;

  logic                    tie_winner;
  logic                    win_sel;
  logic                    sel_rd_wr;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wr_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic                    last_gnt_reg;

  assign tie_winner = ~last_gnt_reg;
`else
  assign tie_winner = 1'b0;
`endif

  always_comb begin
    win_sel = 1'b0;
    if (req_0 && req_1) begin
      win_sel = tie_winner;
    end else if (req_1) begin
      win_sel = 1'b1;
    end
  end

  assign sel_rd_wr   = win_sel ? rd_wr_1   : rd_wr_0;
  assign sel_addr    = win_sel ? addr_1    : addr_0;
  assign sel_wr_data = win_sel ? wr_data_1 : wr_data_0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= 4'd0;
      gnt_reg         <= 2'b00;
      rd_valid_reg    <= 2'b00;
      mem_valid_reg   <= 1'b0;
      mem_rd_wr_reg   <= 1'b0;
      mem_addr_reg    <= '0;
      mem_wr_data_reg <= '0;
      rd_data_reg     <= '0;
      owner_reg       <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_gnt_reg    <= 1'b1;
`endif
    end else begin
      gnt_reg       <= 2'b00;
      rd_valid_reg  <= 2'b00;
      mem_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_0 || req_1) begin
            mem_rd_wr_reg   <= sel_rd_wr;
            mem_addr_reg    <= sel_addr;
            mem_wr_data_reg <= sel_wr_data;
            mem_valid_reg   <= 1'b1;
            gnt_reg         <= win_sel ? 2'b10 : 2'b01;
            owner_reg       <= win_sel;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_gnt_reg    <= win_sel;
`endif
            state_reg       <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_rd_wr_reg) begin
            cnt_reg   <= CNT_LOAD;
            state_reg <= RD_WAIT;
          end else begin
            state_reg <= IDLE;
          end
        end
        RD_WAIT: begin
          if (cnt_reg == 4'd0) begin
            rd_data_reg  <= mem_rd_data;
            rd_valid_reg <= owner_reg ? 2'b10 : 2'b01;
            state_reg    <= IDLE;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign gnt_0           = gnt_reg[0];
  assign gnt_1           = gnt_reg[1];
  assign rd_valid_0      = rd_valid_reg[0];
  assign rd_valid_1      = rd_valid_reg[1];
  assign rd_data         = rd_data_reg;
  assign mem_rd_wr_valid = mem_valid_reg;
  assign mem_rd_wr       = mem_rd_wr_reg;
  assign mem_addr        = mem_addr_reg;
  assign mem_wr_data     = mem_wr_data_reg;

endmodule
